rc4_prga_decrypter: RTL

// - RC4 keystream generator (PRGA) and XOR decrypter. Runs after the KSA shuffle has filled scratch S[0..255].
// - Decrypts msg_len bytes from the encrypted-message ROM into the result RAM.
// - Generalised over the earlier fixed decrypter:
//   - runtime message length;
//   - parametrised memory read latency;
//   - i/j/k cleared on every run;
//   - optional plaintext character check with early abort, for key-search control.

---
 rtl/rc4_prga_decrypter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/rc4_prga_decrypter.sv
// RC4 keystream generator (PRGA) with XOR decryption of a ROM message into a result RAM.
// Runs over a pre-shuffled S box, with an optional plaintext character check that aborts early.
module rc4_prga_decrypter #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    MSG_ADDR_WIDTH = 5,
    parameter int                    RD_LAT         = 2,
    parameter logic [DATA_WIDTH-1:0] CHAR_LO        = 8'h61,
    parameter logic [DATA_WIDTH-1:0] CHAR_HI        = 8'h7A,
    parameter bit                    ALLOW_SPACE    = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [MSG_ADDR_WIDTH:0]   msg_len,
    input  logic                      check_en,
    output logic                      finish,
    output logic                      valid,
    output logic [MSG_ADDR_WIDTH-1:0] fail_idx,
    output logic [DATA_WIDTH-1:0]     s_addr,
    output logic [DATA_WIDTH-1:0]     s_data,
    output logic                      s_wren,
    input  logic [DATA_WIDTH-1:0]     s_q,
    output logic [MSG_ADDR_WIDTH-1:0] msg_addr,
    input  logic [DATA_WIDTH-1:0]     msg_q,
    output logic [MSG_ADDR_WIDTH-1:0] result_addr,
    output logic [DATA_WIDTH-1:0]     result_data,
    output logic                      result_wren
);

    typedef enum logic [2:0] {
        IDLE,
        RD_I,
        RD_J,
        WR_J,
        WR_I,
        RD_F,
        DONE
    } state_t;

    localparam logic [1:0]                LAT_LAST = 2'(RD_LAT - 1);
    localparam logic [1:0]                LAT_ONE  = 2'd1;
    localparam logic [DATA_WIDTH-1:0]     BYTE_ONE = 1;
    localparam logic [DATA_WIDTH-1:0]     SPACE    = 8'h20;
    localparam logic [MSG_ADDR_WIDTH-1:0] K_ONE    = 1;
    localparam logic [MSG_ADDR_WIDTH:0]   LEN_ONE  = 1;

    state_t                    state;
    logic [1:0]                lat_cnt;
    logic [DATA_WIDTH-1:0]     i;
    logic [DATA_WIDTH-1:0]     j;
    logic [DATA_WIDTH-1:0]     si;
    logic [DATA_WIDTH-1:0]     sj;
    logic [MSG_ADDR_WIDTH-1:0] k;
    logic [MSG_ADDR_WIDTH:0]   len;
    logic                      chk;

    logic                      lat_done;
    logic [DATA_WIDTH-1:0]     p;
    logic                      char_ok;
    logic                      last_byte;

    assign lat_done  = (lat_cnt == LAT_LAST);
    assign p         = s_q ^ msg_q;
    assign char_ok   = ((p >= CHAR_LO) && (p <= CHAR_HI)) || (ALLOW_SPACE && (p == SPACE));
    assign last_byte = (({1'b0, k} + LEN_ONE) == len);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            i           <= '0;
            j           <= '0;
            si          <= '0;
            sj          <= '0;
            k           <= '0;
            len         <= '0;
            chk         <= 1'b0;
            finish      <= 1'b0;
            valid       <= 1'b0;
            fail_idx    <= '0;
            s_addr      <= '0;
            s_data      <= '0;
            s_wren      <= 1'b0;
            msg_addr    <= '0;
            result_addr <= '0;
            result_data <= '0;
            result_wren <= 1'b0;
        end else begin
            // NOTE: the result write is a one-cycle pulse that overlaps the first
            // cycle of the next byte's S[i] read (or the first DONE cycle).
            result_wren <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        len      <= msg_len;
                        chk      <= check_en;
                        i        <= BYTE_ONE;
                        j        <= '0;
                        k        <= '0;
                        lat_cnt  <= '0;
                        fail_idx <= '0;
                        if (msg_len == '0) begin
                            valid  <= 1'b1;
                            finish <= 1'b1;
                            state  <= DONE;
                        end else begin
                            valid  <= 1'b0;
                            s_addr <= BYTE_ONE;
                            state  <= RD_I;
                        end
                    end
                end

                RD_I: begin
                    if (lat_done) begin
                        si      <= s_q;
                        j       <= j + s_q;
                        s_addr  <= j + s_q;
                        lat_cnt <= '0;
                        state   <= RD_J;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_ONE;
                    end
                end

                RD_J: begin
                    if (lat_done) begin
                        sj      <= s_q;
                        s_addr  <= j;
                        s_data  <= si;
                        s_wren  <= 1'b1;
                        lat_cnt <= '0;
                        state   <= WR_J;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_ONE;
                    end
                end

                // Writing S[j] before S[i] leaves sj at the shared address when i == j.
                WR_J: begin
                    s_addr <= i;
                    s_data <= sj;
                    state  <= WR_I;
                end

                WR_I: begin
                    s_wren   <= 1'b0;
                    s_addr   <= si + sj;
                    msg_addr <= k;
                    lat_cnt  <= '0;
                    state    <= RD_F;
                end

                RD_F: begin
                    if (lat_done) begin
                        result_addr <= k;
                        result_data <= p;
                        result_wren <= 1'b1;
                        lat_cnt     <= '0;
                        if (chk && !char_ok) begin
                            valid    <= 1'b0;
                            fail_idx <= k;
                            finish   <= 1'b1;
                            state    <= DONE;
                        end else if (last_byte) begin
                            valid    <= 1'b1;
                            fail_idx <= '0;
                            finish   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            k      <= k + K_ONE;
                            i      <= i + BYTE_ONE;
                            s_addr <= i + BYTE_ONE;
                            state  <= RD_I;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + LAT_ONE;
                    end
                end

                DONE: begin
                    if (!start) begin
                        finish <= 1'b0;
                        state  <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
